uart_receiver: RTL and testbench

// - Receive side of the UART link; counterpart to the transmitter path (tx FSM + level/pulse output mux).
// - Recovers 8N1 (optionally 8E1/8O1) frames from the asynchronous serial input.
// - Presents each received byte with a one-cycle valid strobe, plus parity and framing error flags.
// - Sits between the board RX pin and the consumer logic (loopback checker / display).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_receiver.sv | 140 ++++++++++++++
 tb/tb_uart_receiver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default bit timing and a parity helper.
// The transmitter side imports this package as well.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    // Expected parity bit for a word; narrower words are zero-extended by the caller.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin plus a 1->0 edge detector on the synced line.
// All flops reset to 1 so that a reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s,
    output logic fall_pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rx_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s       = sync_q;
    assign fall_pulse = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: recovers 8N1 / 8E1 / 8O1 frames and presents each word with a one-cycle
// valid strobe plus parity and framing error flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    uart_rx_state_t state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic rx_s;
    logic fall_pulse;
    logic half_hit;
    logic bit_done;

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .rx_s       (rx_s),
        .fall_pulse (fall_pulse)
    );

    assign half_hit = (cnt_q == HALF_LAST);
    assign bit_done = (cnt_q == FULL_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // A high line at mid start bit is treated as a glitch; a low stop bit parks in WAIT_IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (fall_pulse) state_d = START;
            START:     if (half_hit) state_d = rx_s ? IDLE : DATA;
            DATA:      if (bit_done && bit_idx_q == LAST_BIT) state_d = PARITY_EN ? PARITY : STOP;
            PARITY:    if (bit_done) state_d = STOP;
            STOP:      if (bit_done) state_d = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        case (state_q)
            IDLE, WAIT_IDLE: cnt_d = '0;
            START: begin
                if (half_hit) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                end
            end
            STOP: begin
                // The word is delivered even when parity or framing is bad.
                if (bit_done) begin
                    cnt_d        = '0;
                    rx_valid_d   = 1'b1;
                    rx_data_d    = shift_q;
                    parity_err_d = PARITY_EN && (par_bit_q != uart_parity(8'(shift_q), PARITY_ODD));
                    frame_err_d  = ~rx_s;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: two instances (8N1 and 8E1) at 16 clocks per bit.
// Stimulus pushes the expected word and strobe cycle; per-instance monitors pop and compare.
module tb_uart_receiver;

    localparam int C = 16;
    localparam int H = C / 2;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic       busy_a, busy_b;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (8),
        .PARITY_EN    (1'b0),
        .PARITY_ODD   (1'b0)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_a),
        .rx_data    (data_a),
        .rx_valid   (valid_a),
        .parity_err (perr_a),
        .frame_err  (ferr_a),
        .busy       (busy_a)
    );

    uart_receiver #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (8),
        .PARITY_EN    (1'b1),
        .PARITY_ODD   (1'b0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_b),
        .rx_data    (data_b),
        .rx_valid   (valid_b),
        .parity_err (perr_b),
        .frame_err  (ferr_b),
        .busy       (busy_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic driveBit(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (C) @(negedge clk);
    endtask

    // Called on a negedge; the start bit is first sampled at the next posedge (T0).
    task automatic applyStimulus(input bit sel, input logic [7:0] data, input logic par_bit,
                                 input logic stop_bit, input logic [7:0] exp_data,
                                 input logic exp_perr, input logic exp_ferr);
        exp_t e;
        int   t0;
        int   nbits;
        t0     = cyc + 1;
        nbits  = sel ? 10 : 9;
        e.data = exp_data;
        e.perr = exp_perr;
        e.ferr = exp_ferr;
        e.cyc  = t0 + 3 + H + nbits * C - 1;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
        driveBit(sel, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(sel, data[i]);
        if (sel) driveBit(sel, par_bit);
        driveBit(sel, stop_bit);
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_data"},  32'(data_a),  32'h0);
        checkOutput({tag, "_valid"}, 32'(valid_a), 32'h0);
        checkOutput({tag, "_perr"},  32'(perr_a),  32'h0);
        checkOutput({tag, "_ferr"},  32'(ferr_a),  32'h0);
        checkOutput({tag, "_busy"},  32'(busy_a),  32'h0);
    endtask

    always @(negedge clk) begin
        if (valid_a === 1'b1) begin
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_strobe_A: strobe at cycle %0d, expected none", cyc);
            end else begin
                e_a = q_a.pop_front();
                checkOutput("A_data",  32'(data_a), 32'(e_a.data));
                checkOutput("A_perr",  32'(perr_a), 32'(e_a.perr));
                checkOutput("A_ferr",  32'(ferr_a), 32'(e_a.ferr));
                checkOutput("A_cycle", cyc,         e_a.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b === 1'b1) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_strobe_B: strobe at cycle %0d, expected none", cyc);
            end else begin
                e_b = q_b.pop_front();
                checkOutput("B_data",  32'(data_b), 32'(e_b.data));
                checkOutput("B_perr",  32'(perr_b), 32'(e_b.perr));
                checkOutput("B_ferr",  32'(ferr_b), 32'(e_b.ferr));
                checkOutput("B_cycle", cyc,         e_b.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        logic [7:0] d81;
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        checkResetA("reset");
        checkOutput("reset_B_busy", 32'(busy_b), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] good 8N1 frame 0xA5");
        applyStimulus(1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("a5_busy_after", 32'(busy_a), 32'h0);
        checkOutput("a5_data_held",  32'(data_a), 32'hA5);

        $display("[TB] start-bit glitch");
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("glitch_busy_high", 32'(busy_a), 32'h1);
        rx_a = 1'b1;
        k = 0;
        while (busy_a === 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        checkOutput("glitch_busy_drop", 32'(busy_a), 32'h0);
        checkOutput("glitch_data_held", 32'(data_a), 32'hA5);
        repeat (10) @(negedge clk);

        $display("[TB] framing error 0x3C with line held low");
        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
        repeat (40) @(negedge clk);
        checkOutput("break_busy_waiting", 32'(busy_a), 32'h1);
        checkOutput("break_ferr_held",    32'(ferr_a), 32'h1);
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("break_busy_released", 32'(busy_a), 32'h0);
        applyStimulus(1'b0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        $display("[TB] even parity 0x07");
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("parity_B_perr_held", 32'(perr_b), 32'h0);

        $display("[TB] back-to-back 0x00 then 0xFF");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        $display("[TB] reset during data bit 4 of 0x81");
        d81 = 8'h81;
        driveBit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b0, d81[i]);
        rx_a = d81[4];
        repeat (H) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rx_a  = 1'b1;
        checkResetA("midreset");
        repeat (2 * 10 * C) @(negedge clk);
        checkOutput("midreset_data_still_zero", 32'(data_a), 32'h0);
        applyStimulus(1'b0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);

        repeat (20) @(negedge clk);
        checkOutput("A_pending_expected", q_a.size(), 0);
        checkOutput("B_pending_expected", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
